mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit: turns the load or store held in the M pipeline register into a request/acknowledge transaction on the data bus.
- Produces `mem_valid_m`, which the hazard unit consumes to stall F/D/E/M while a load is outstanding.
- Returns aligned, sign- or zero-extended load data toward the W stage.
- Flags misaligned accesses and bus timeouts.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ without `dbus_ack` before the access is abandoned; 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `stall_m`  in  1  M-stage hold from the hazard unit; M register unchanged at the next edge
- `mem_read_m`  in  1  M instruction is a load
- `mem_write_m`  in  1  M instruction is a store
- `funct3_m`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr_m`  in  32  byte address from ALU
- `wdata_m`  in  32  store data (rs2, forwarded)
- `read_data_m`  out  32  extended load data, valid while `mem_valid_m`
- `mem_valid_m`  out  1  access complete; data/flags valid
- `store_busy_m`  out  1  store in M not yet complete
- `misaligned_m`  out  1  completed access was misaligned (no bus traffic)
- `bus_error_m`  out  1  completed access timed out
- `dbus_req`  out  1  bus request
- `dbus_we`  out  1  1 = write
- `dbus_addr`  out  32  word address, `{addr_m[31:2],2'b00}`
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_wstrb`  out  4  byte enables; 0000 on reads
- `dbus_rdata`  in  32  read word, valid with `dbus_ack`
- `dbus_ack`  in  1  bus completion, one-cycle pulse

Behaviour:
- Reset: `rst_n` low at an edge forces state IDLE and clears all outputs and the timeout counter. This holds even mid-REQ; an ack arriving while or after reset is applied is ignored.
- FSM states:
  - IDLE: no access in progress.
  - REQ: `dbus_req`=1. Bus outputs are registered and stable until ack.
  - DONE: `mem_valid_m`=1; result held.
- Op qualification: op = `mem_read_m` | `mem_write_m`. If both are set, treat as load (`dbus_we`=0).
- Misalignment:
  - H/HU/SH misaligned when `addr[0]`=1.
  - W/SW misaligned when `addr[1:0]`≠0.
  - Byte accesses are never misaligned.
- IDLE transitions:
  - op and aligned → REQ; latch addr, we, wdata, wstrb, funct3, `addr[1:0]`.
  - op and misaligned → DONE with `misaligned_m`=1, `read_data_m`=0, and no `dbus_req` ever asserted.
  - No op → stay IDLE.
- REQ transitions:
  - `dbus_ack` sampled 1 → DONE; latch extended `dbus_rdata` (loads) or 0 (stores). `dbus_req` drops in the same edge.
  - Timeout counter increments each cycle in REQ. When it reaches `TIMEOUT_CYCLES` with no ack → DONE, `bus_error_m`=1, `read_data_m`=0, `dbus_req` drops.
  - Ack on the same cycle as timeout: ack wins, no error.
- DONE transitions:
  - `stall_m`=0 at the edge → IDLE; clear `mem_valid_m`, `misaligned_m`, `bus_error_m`.
  - `stall_m`=1 → hold everything.
  - No re-issue of the same instruction, ever.
- Latency: minimum 3 cycles per aligned access (IDLE→REQ→DONE→IDLE), assuming ack in the first REQ cycle. Back-to-back accesses re-enter REQ the cycle after DONE exits.
- Load extraction, using byte offset o = `addr[1:0]`:
  - B: sign-extend byte o.
  - BU: zero-extend byte o.
  - H: sign-extend halfword `o[1]`.
  - HU: zero-extend halfword `o[1]`.
  - W: whole word.
- Store lanes:
  - SB: `wstrb`=0001<<o, `wdata`={4{b}}.
  - SH: `wstrb`=0011<<o, `wdata`={2{h}}.
  - SW: `wstrb`=1111.
- `store_busy_m` = `mem_write_m` & !`mem_read_m` & state≠DONE. It is combinational, and integration ORs it into the M/upstream stall.
- `mem_valid_m` is registered (= state DONE). For loads, `stall_m` deasserts the cycle `mem_valid_m` rises, so DONE lasts exactly 1 cycle unless held by `stall_m`.
- Undefined `funct3` (011, 11x): treated as W.

Test Plan:
- LW `addr`=0x100, ack after 2 cycles with rdata 0xDEADBEEF:
  - `dbus_req` high 2 cycles, `dbus_addr`=0x100, `wstrb`=0000.
  - `mem_valid_m`=1 one cycle, `read_data_m`=0xDEADBEEF.
- LB/LBU `addr`=0x203, rdata 0x80112233 → `read_data_m`=0xFFFFFF80 / 0x00000080; LH `addr`=0x202 same rdata → 0xFFFF8011.
- SB `addr`=0x301, `wdata`=0x000000A5, ack immediately:
  - `wstrb`=0010, `dbus_wdata`=0xA5A5A5A5, `we`=1.
  - `store_busy_m` high until DONE.
- LW `addr`=0x102 → no `dbus_req`; next cycle `mem_valid_m`=1, `misaligned_m`=1, data 0.
- `TIMEOUT_CYCLES`=4, no ack:
  - `dbus_req` high exactly 4 cycles, then `mem_valid_m`=1, `bus_error_m`=1.
  - Repeat with ack on cycle 4 → no error.
- `rst_n` low during REQ with ack in the same cycle → IDLE, `dbus_req`=0, `mem_valid_m`=0 next cycle; no data latched.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit. Converts the load or store sitting in the
// M pipeline register into one request/acknowledge transaction on the data
// bus, returns extended load data toward W, and reports misaligned accesses
// and bus timeouts. mem_valid_m tells the hazard unit the access is complete.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] read_data_m,
    output logic        mem_valid_m,
    output logic        store_busy_m,
    output logic        misaligned_m,
    output logic        bus_error_m,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_wstrb,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);

    // Counter must be able to hold TIMEOUT_CYCLES; keep at least one bit so
    // the disabled (0) configuration still elaborates.
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // The access is abandoned at the edge that ends the TIMEOUT_CYCLES-th
    // REQ cycle, i.e. when the counter (0 on REQ entry) reads TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    logic [CW-1:0]   timeout_cnt;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;

    logic            op;
    logic            is_store;
    logic            size_byte;
    logic            size_half;
    logic            misaligned;
    logic [3:0]      wstrb_n;
    logic [31:0]     wdata_n;

    // Pick the addressed byte/halfword out of the bus word and extend it.
    // Undefined funct3 encodings fall through to a full-word result.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b100:  result = {24'b0, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b101:  result = {16'b0, lane_h};
            default: result = word;
        endcase
        return result;
    endfunction

    // Decode the M-stage instruction: access size, alignment and store lanes.
    // A load+store combination is treated as a load, so it never writes.
    always_comb begin
        op         = mem_read_m | mem_write_m;
        is_store   = mem_write_m & ~mem_read_m;
        size_byte  = (funct3_m[1:0] == 2'b00);
        size_half  = (funct3_m[1:0] == 2'b01);
        misaligned = (size_half & addr_m[0]) |
                     (~size_byte & ~size_half & (addr_m[1:0] != 2'b00));
        wstrb_n    = 4'b0000;
        if (is_store) begin
            if (size_byte)
                wstrb_n = 4'b0001 << addr_m[1:0];
            else if (size_half)
                wstrb_n = 4'b0011 << addr_m[1:0];
            else
                wstrb_n = 4'b1111;
        end
        if (size_byte)
            wdata_n = {4{wdata_m[7:0]}};
        else if (size_half)
            wdata_n = {2{wdata_m[15:0]}};
        else
            wdata_n = wdata_m;
    end

    // A store holds the pipeline until its acknowledge has been seen.
    assign store_busy_m = mem_write_m & ~mem_read_m & (state != DONE);

    // Access sequencer: IDLE -> REQ -> DONE -> IDLE, with misaligned accesses
    // skipping the bus entirely and timeouts forcing DONE with an error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            timeout_cnt  <= '0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            read_data_m  <= 32'h0;
            mem_valid_m  <= 1'b0;
            misaligned_m <= 1'b0;
            bus_error_m  <= 1'b0;
            dbus_req     <= 1'b0;
            dbus_we      <= 1'b0;
            dbus_addr    <= 32'h0;
            dbus_wdata   <= 32'h0;
            dbus_wstrb   <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        if (misaligned) begin
                            state        <= DONE;
                            mem_valid_m  <= 1'b1;
                            misaligned_m <= 1'b1;
                            bus_error_m  <= 1'b0;
                            read_data_m  <= 32'h0;
                        end else begin
                            state       <= REQ;
                            timeout_cnt <= '0;
                            funct3_q    <= funct3_m;
                            offset_q    <= addr_m[1:0];
                            dbus_req    <= 1'b1;
                            dbus_we     <= is_store;
                            dbus_addr   <= {addr_m[31:2], 2'b00};
                            dbus_wdata  <= wdata_n;
                            dbus_wstrb  <= wstrb_n;
                        end
                    end
                end
                REQ: begin
                    if (dbus_ack) begin
                        state       <= DONE;
                        dbus_req    <= 1'b0;
                        mem_valid_m <= 1'b1;
                        bus_error_m <= 1'b0;
                        read_data_m <= dbus_we ? 32'h0
                                               : extract_load(dbus_rdata, funct3_q, offset_q);
                    end else if ((TIMEOUT_CYCLES != 0) && (timeout_cnt == TO_LAST)) begin
                        state       <= DONE;
                        dbus_req    <= 1'b0;
                        mem_valid_m <= 1'b1;
                        bus_error_m <= 1'b1;
                        read_data_m <= 32'h0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!stall_m) begin
                        state        <= IDLE;
                        mem_valid_m  <= 1'b0;
                        misaligned_m <= 1'b0;
                        bus_error_m  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dbus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
